rgb2ycbcr_stream: RTL and testbench

Parametrised, back-pressurable RGB→YCbCr colour converter for the JPEG front end; successor to the fixed 8-bit enable-pipelined converter. Accepts one pixel per cycle over a valid/ready handshake and supports 8–12-bit components. Conversion mode (full-range JFIF or studio-range BT.601) is selectable per pixel. Output feeds the block-splitter/DCT path, with optional JPEG level shift.

---
 rtl/rgb2ycbcr_stream.sv | 205 ++++++++++++++++++++
 tb/tb_rgb2ycbcr_stream.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2ycbcr_stream.sv
// rgb2ycbcr_stream: three-stage valid/ready RGB -> YCbCr converter, 8..12-bit
// components, per-pixel full-range (JFIF) or studio-range (BT.601) mode.
// Optional build macro RGB2YCBCR_LEVEL_SHIFT_EN: outputs become two's-complement
// values centred on zero (2^(PIX_W-1) subtracted after clamping) for the DCT.
// Lane 0 = Y, lane 1 = Cb, lane 2 = Cr; input lane 0 = R, 1 = G, 2 = B.

module rgb2ycbcr_lane #(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 14,
    parameter int ACC_W  = PIX_W + FRAC_W + 3,
    parameter int LANE   = 0
) (
    input  logic [PIX_W-1:0]        r_i,
    input  logic [PIX_W-1:0]        g_i,
    input  logic [PIX_W-1:0]        b_i,
    input  logic                    mode_i,
    output logic signed [ACC_W-1:0] sum_o,
    input  logic signed [ACC_W-1:0] acc_i,
    output logic [PIX_W-1:0]        pix_o
);
    // Reference coefficients at 14 fraction bits, (R, G, B) per output row.
    function automatic int coef14(input int l, input int c, input bit m);
        int k;
        k = 0;
        if (!m) begin
            case (l * 3 + c)
                0: k = 4899;  1: k = 9617;  2: k = 1868;
                3: k = -2765; 4: k = -5427; 5: k = 8192;
                6: k = 8192;  7: k = -6860; 8: k = -1332;
                default: k = 0;
            endcase
        end else begin
            case (l * 3 + c)
                0: k = 4207;  1: k = 8260;  2: k = 1604;
                3: k = -2428; 4: k = -4768; 5: k = 7196;
                6: k = 7196;  7: k = -6026; 8: k = -1170;
                default: k = 0;
            endcase
        end
        return k;
    endfunction

    // Rescale to FRAC_W fraction bits, rounding half away from zero.
    function automatic int scale(input int c14);
        longint m;
        m = longint'(c14) <<< FRAC_W;
        if (c14 >= 0) return int'((m + 8192) / 16384);
        else          return -int'((-m + 8192) / 16384);
    endfunction

    localparam logic signed [ACC_W-1:0] KF_R = ACC_W'(scale(coef14(LANE, 0, 1'b0)));
    localparam logic signed [ACC_W-1:0] KF_G = ACC_W'(scale(coef14(LANE, 1, 1'b0)));
    localparam logic signed [ACC_W-1:0] KF_B = ACC_W'(scale(coef14(LANE, 2, 1'b0)));
    localparam logic signed [ACC_W-1:0] KS_R = ACC_W'(scale(coef14(LANE, 0, 1'b1)));
    localparam logic signed [ACC_W-1:0] KS_G = ACC_W'(scale(coef14(LANE, 1, 1'b1)));
    localparam logic signed [ACC_W-1:0] KS_B = ACC_W'(scale(coef14(LANE, 2, 1'b1)));

    localparam int OFF_C  = 1 << (PIX_W - 1);
    localparam int OFF_YS = 16 << (PIX_W - 8);
    localparam logic signed [ACC_W-1:0] OFF_F = ACC_W'((LANE == 0 ? 0 : OFF_C) << FRAC_W);
    localparam logic signed [ACC_W-1:0] OFF_S = ACC_W'((LANE == 0 ? OFF_YS : OFF_C) << FRAC_W);

    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1 << (FRAC_W - 1));
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);
`ifdef RGB2YCBCR_LEVEL_SHIFT_EN
    // Subtracting 2^(PIX_W-1) from a value in [0, 2^PIX_W-1] is an MSB flip.
    localparam logic [PIX_W-1:0] LS_MASK = PIX_W'(1) << (PIX_W - 1);
`else
    localparam logic [PIX_W-1:0] LS_MASK = '0;
`endif

    logic signed [ACC_W-1:0] r_s, g_s, b_s;
    logic signed [ACC_W-1:0] rnd, shr;
    logic [PIX_W-1:0]        clamp;

    assign r_s = $signed(ACC_W'(r_i));
    assign g_s = $signed(ACC_W'(g_i));
    assign b_s = $signed(ACC_W'(b_i));

    // Offset plus signed dot product for the mode carried with this pixel.
    always_comb begin
        if (mode_i) sum_o = OFF_S + KS_R * r_s + KS_G * g_s + KS_B * b_s;
        else        sum_o = OFF_F + KF_R * r_s + KF_G * g_s + KF_B * b_s;
    end

    // Round to nearest, drop fraction, clamp to the component range.
    always_comb begin
        rnd = acc_i + HALF;
        shr = rnd >>> FRAC_W;
        if (shr < 0)             clamp = '0;
        else if (shr > PIX_MAX)  clamp = '1;
        else                     clamp = shr[PIX_W-1:0];
        pix_o = clamp ^ LS_MASK;
    end
endmodule

module rgb2ycbcr_stream #(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3*PIX_W-1:0]   in_data,
    input  logic                 in_mode,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*PIX_W-1:0]   out_data,
    output logic                 out_last
);
    localparam int NUM_LANES = 3;
    localparam int ACC_W     = PIX_W + FRAC_W + 3;

    logic [3:1] vld_q, vld_d, adv;
    logic [3:1] last_q, last_d;
    logic       mode_q, mode_d;
    logic [NUM_LANES-1:0][PIX_W-1:0] rgb_q, rgb_d;
    logic [NUM_LANES-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [NUM_LANES-1:0][PIX_W-1:0] pix_q, pix_d;
    logic [NUM_LANES-1:0][ACC_W-1:0] sum_c;
    logic [NUM_LANES-1:0][PIX_W-1:0] pix_c;

    // Per-component datapath: S1->S2 dot product, S2->S3 round/clamp.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        rgb2ycbcr_lane #(
            .PIX_W (PIX_W),
            .FRAC_W(FRAC_W),
            .ACC_W (ACC_W),
            .LANE  (i)
        ) u_lane (
            .r_i   (rgb_q[0]),
            .g_i   (rgb_q[1]),
            .b_i   (rgb_q[2]),
            .mode_i(mode_q),
            .sum_o (sum_c[i]),
            .acc_i (acc_q[i]),
            .pix_o (pix_c[i])
        );
    end

    // A stage may advance when empty or when the stage after it advances.
    always_comb begin
        adv[3] = !vld_q[3] || out_ready;
        adv[2] = !vld_q[2] || adv[3];
        adv[1] = !vld_q[1] || adv[2];
    end

    // Next state: valids shift on advance; data loads only with a valid source.
    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        mode_d = mode_q;
        rgb_d  = rgb_q;
        acc_d  = acc_q;
        pix_d  = pix_q;
        if (adv[1]) begin
            vld_d[1] = in_valid;
            if (in_valid) begin
                rgb_d     = in_data;
                mode_d    = in_mode;
                last_d[1] = in_last;
            end
        end
        if (adv[2]) begin
            vld_d[2] = vld_q[1];
            if (vld_q[1]) begin
                acc_d     = sum_c;
                last_d[2] = last_q[1];
            end
        end
        if (adv[3]) begin
            vld_d[3] = vld_q[2];
            if (vld_q[2]) begin
                pix_d     = pix_c;
                last_d[3] = last_q[2];
            end
        end
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            last_q <= '0;
            mode_q <= 1'b0;
            rgb_q  <= '0;
            acc_q  <= '0;
            pix_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
            mode_q <= mode_d;
            rgb_q  <= rgb_d;
            acc_q  <= acc_d;
            pix_q  <= pix_d;
        end
    end

    assign in_ready  = adv[1];
    assign out_valid = vld_q[3];
    assign out_data  = pix_q;
    assign out_last  = last_q[3];
endmodule

// File: tb/tb_rgb2ycbcr_stream.sv
// Directed bench for rgb2ycbcr_stream (8-bit instance plus a 12-bit instance).
module tb_rgb2ycbcr_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_mode, in_last, out_ready;
    logic [23:0] in_data;
    logic        in_ready, out_valid, out_last;
    logic [23:0] out_data;

    logic        in_valid12, in_mode12, in_last12, out_ready12;
    logic [35:0] in_data12;
    logic        in_ready12, out_valid12, out_last12;
    logic [35:0] out_data12;

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    bit mon_en = 1'b0;
    logic [24:0] q[$];

    rgb2ycbcr_stream #(.PIX_W(8), .FRAC_W(14)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    rgb2ycbcr_stream #(.PIX_W(12), .FRAC_W(14)) dut12 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid12), .in_ready(in_ready12), .in_data(in_data12),
        .in_mode(in_mode12), .in_last(in_last12),
        .out_valid(out_valid12), .out_ready(out_ready12), .out_data(out_data12),
        .out_last(out_last12)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] lsh8(input logic [23:0] x);
`ifdef RGB2YCBCR_LEVEL_SHIFT_EN
        return x ^ 24'h808080;
`else
        return x;
`endif
    endfunction

    function automatic logic [35:0] lsh12(input logic [35:0] x);
`ifdef RGB2YCBCR_LEVEL_SHIFT_EN
        return x ^ 36'h800800800;
`else
        return x;
`endif
    endfunction

    // Straight integer evaluation of the conversion equations, 8-bit, 14 fraction bits.
    function automatic logic [23:0] ref8(input int r, input int g, input int b, input bit m);
        int k[9];
        int off, s, v;
        logic [23:0] res;
        res = '0;
        if (!m) k = '{4899, 9617, 1868, -2765, -5427, 8192, 8192, -6860, -1332};
        else    k = '{4207, 8260, 1604, -2428, -4768, 7196, 7196, -6026, -1170};
        for (int l = 0; l < 3; l++) begin
            off = (l == 0) ? (m ? 16 : 0) : 128;
            s = off * 16384 + k[3*l] * r + k[3*l+1] * g + k[3*l+2] * b + 8192;
            v = s >>> 14;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            res[l*8 +: 8] = 8'(v);
        end
        return lsh8(res);
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output scoreboard: every accepted output must match the head of q.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            logic [24:0] e;
            n_out++;
            total++;
            assert (q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_out observed=%0h expected=none", {out_last, out_data});
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("stream_out", 40'({out_last, out_data}), 40'(e));
            end
        end
    end

    // Present one pixel and hold it until accepted; returns just after the transfer edge.
    task automatic send(input logic [23:0] d, input logic m, input logic l);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1; in_data = d; in_mode = m; in_last = l;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 40'(n), 40'(0));
    endtask

    // Single pixel with out_ready high: check latency and result.
    task automatic one(input logic [23:0] d, input logic m, input logic [23:0] exp, input string tag);
        int lat;
        lat = 0;
        send(d, m, 1'b0);
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        chk({tag, "_lat"}, 40'(lat), 40'(3));
        chk(tag, 40'({out_last, out_data}), 40'({1'b0, lsh8(exp)}));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 40'(q.size()), 40'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, n0;
        bit rnd_done;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_valid12 = 1'b0; in_data12 = '0; in_mode12 = 1'b0; in_last12 = 1'b0; out_ready12 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 40'(out_valid), 40'(0));
        chk("rst_out_data",  40'(out_data),  40'(0));
        chk("rst_out_last",  40'(out_last),  40'(0));
        chk("rst_in_ready",  40'(in_ready),  40'(1));
        chk("rst_out_valid12", 40'(out_valid12), 40'(0));
        @(posedge clk); #1;

        // Full range, then studio range, single pixels ({B,G,R} in, {Cr,Cb,Y} out)
        one({8'd255, 8'd255, 8'd255}, 1'b0, {8'd128, 8'd128, 8'd255}, "full_white");
        one({8'd0,   8'd0,   8'd0},   1'b0, {8'd128, 8'd128, 8'd0},   "full_black");
        one({8'd0,   8'd0,   8'd255}, 1'b0, {8'd255, 8'd85,  8'd76},  "full_red");
        one({8'd255, 8'd255, 8'd255}, 1'b1, {8'd128, 8'd128, 8'd235}, "std_white");
        one({8'd0,   8'd0,   8'd0},   1'b1, {8'd128, 8'd128, 8'd16},  "std_black");
        one({8'd0,   8'd0,   8'd255}, 1'b1, {8'd240, 8'd90,  8'd81},  "std_red");

        // Alternating mode on back-to-back pixels
        mon_en = 1'b1;
        q.push_back({1'b0, lsh8({8'd128, 8'd128, 8'd255})});
        q.push_back({1'b0, lsh8({8'd128, 8'd128, 8'd235})});
        q.push_back({1'b0, lsh8({8'd128, 8'd128, 8'd0})});
        q.push_back({1'b0, lsh8({8'd128, 8'd128, 8'd16})});
        q.push_back({1'b0, lsh8({8'd240, 8'd90,  8'd81})});
        q.push_back({1'b1, lsh8({8'd255, 8'd85,  8'd76})});
        send({8'd255, 8'd255, 8'd255}, 1'b0, 1'b0);
        send({8'd255, 8'd255, 8'd255}, 1'b1, 1'b0);
        send({8'd0,   8'd0,   8'd0},   1'b0, 1'b0);
        send({8'd0,   8'd0,   8'd0},   1'b1, 1'b0);
        send({8'd0,   8'd0,   8'd255}, 1'b1, 1'b0);
        send({8'd0,   8'd0,   8'd255}, 1'b0, 1'b1);
        drain();

        // Backpressure: greys 40..240, last on the 6th; fill with out_ready low
        for (int k = 1; k <= 6; k++)
            q.push_back({(k == 6), lsh8({8'd128, 8'd128, 8'(k * 40)})});
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++)
            send({3{8'(k * 40)}}, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 40'(in_ready), 40'(0));
            chk("bp_out_valid",    40'(out_valid), 40'(1));
            chk("bp_out_stable",   40'({out_last, out_data}), 40'({1'b0, lsh8({8'd128, 8'd128, 8'd40})}));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 4; k <= 6; k++)
            send({3{8'(k * 40)}}, 1'b0, (k == 6));
        drain();

        // Random out_ready and input gaps over 1000 pixels
        rnd_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 1000; p++) begin
                    logic [7:0] r, g, b;
                    logic m;
                    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); m = 1'($urandom);
                    q.push_back({(p % 8 == 7), ref8(int'(r), int'(g), int'(b), m)});
                    send({b, g, r}, m, (p % 8 == 7));
                    if ($urandom_range(0, 7) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                drain();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset with three pixels in flight: none may ever come out
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++)
            send({3{8'(k * 17)}}, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 40'(out_valid), 40'(0));
        chk("midrst_in_ready",  40'(in_ready),  40'(1));
        n0 = n_out;
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_no_emit", 40'(n_out), 40'(n0));
        mon_en = 1'b0;
        @(posedge clk); #1;

        // 12-bit instance: full-range white, latency still 3
        in_valid12 = 1'b1;
        in_data12  = {12'd4095, 12'd4095, 12'd4095};
        @(negedge clk);
        chk("w12_in_ready", 40'(in_ready12), 40'(1));
        @(posedge clk); #1;
        in_valid12 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid12 && lat < 10);
        chk("w12_lat", 40'(lat), 40'(3));
        chk("w12_data", 40'(out_data12), 40'(lsh12({12'd2048, 12'd2048, 12'd4095})));
        chk("w12_last", 40'(out_last12), 40'(0));
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
